// File: rtl/dctl_pkg.sv
// dctl_pkg: shared state encoding and bus constants for the DMA block sequencer
package dctl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_REQ, ST_RD_WAIT, ST_ROT, ST_WR_REQ, ST_WR_WAIT, ST_NEXT, ST_FIN
  } state_t;
  localparam logic [2:0] SIZE_WORD = 3'b010;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;
  localparam int MAX_BEATS = 16;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
endpackage

// File: rtl/dctl_beat_cnt.sv
// dctl_beat_cnt: counts accepted AHB address beats of one burst and flags completion
module dctl_beat_cnt
  import dctl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             first,
  input  logic [1:0]       htrans,
  input  logic             hready,
  input  logic [CNT_W-1:0] beats,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  logic beat;
  assign done = cnt == beats;
  assign beat = (htrans == HTRANS_NSEQ || htrans == HTRANS_SEQ) && hready && !done;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (first) cnt <= CNT_W'(1);
    else if (clr) cnt <= '0;
    else if (beat) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dma_ctrl.sv
// dma_ctrl: steps the DMA through read, rotate and write for every block of a frame
module dma_ctrl
  import dctl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BLK_W = 16
) (
  input  logic              I_DCTL_HCLK,
  input  logic              I_DCTL_HRESET_N,
  input  logic              I_DCTL_START,
  input  logic              I_DCTL_ABORT,
  input  logic [ADDR_W-1:0] I_DCTL_SRC_BASE,
  input  logic [ADDR_W-1:0] I_DCTL_DST_BASE,
  input  logic [BLK_W-1:0]  I_DCTL_NUM_BLOCKS,
  input  logic [4:0]        I_DCTL_BEATS,
  input  logic              I_DCTL_DMA_READY,
  input  logic [1:0]        I_DCTL_HTRANS,
  input  logic              I_DCTL_HREADY,
  input  logic              I_DCTL_ROT_DONE,
  output logic [ADDR_W-1:0] O_DCTL_DMA_ADDR,
  output logic [4:0]        O_DCTL_DMA_COUNT,
  output logic [2:0]        O_DCTL_DMA_SIZE,
  output logic              O_DCTL_DMA_WRITE,
  output logic              O_DCTL_DMA_START,
  output logic              O_DCTL_DMA_STOP,
  output logic              O_DCTL_DMA_RESET,
  output logic              O_DCTL_ROT_START,
  output logic              O_DCTL_BUSY,
  output logic              O_DCTL_DONE,
  output logic              O_DCTL_ERR,
  output logic [BLK_W-1:0]  O_DCTL_BLK_IDX
);
  state_t state, nxt;
  logic [ADDR_W-1:0] src, dst, src_d, dst_d, step, addr_d;
  logic [BLK_W-1:0] nblk, blk, blk_d;
  logic [4:0] beats, beats_d, count_d;
  logic kill, accept, advance, last, first, waiting, cnt_done, leave;
  logic req_d, write_d, busy_d, rot_d;
  assign kill = I_DCTL_ABORT && state != ST_IDLE;
  assign accept = state == ST_IDLE && I_DCTL_START && I_DCTL_NUM_BLOCKS != '0 && I_DCTL_BEATS != '0;
  assign last = blk == nblk - 1'b1;
  assign advance = state == ST_NEXT && !kill;
  assign first = (state == ST_RD_REQ || state == ST_WR_REQ) && I_DCTL_DMA_READY;
  assign waiting = state == ST_RD_WAIT || state == ST_WR_WAIT;
  assign leave = cnt_done && I_DCTL_HREADY;
  assign step = ADDR_W'({beats, 2'b00});
  assign O_DCTL_DMA_SIZE = SIZE_WORD;
  assign O_DCTL_BLK_IDX = blk;
  dctl_beat_cnt u_beat_cnt (
    .clk    (I_DCTL_HCLK),
    .rst_n  (I_DCTL_HRESET_N),
    .clr    (!waiting),
    .first  (first),
    .htrans (I_DCTL_HTRANS),
    .hready (I_DCTL_HREADY),
    .beats  (beats),
    .done   (cnt_done)
  );
  always_ff @(posedge I_DCTL_HCLK)
    if (!I_DCTL_HRESET_N) state <= ST_IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    nxt = accept ? ST_RD_REQ : ST_IDLE;
      ST_RD_REQ:  nxt = I_DCTL_DMA_READY ? ST_RD_WAIT : ST_RD_REQ;
      ST_RD_WAIT: nxt = leave ? ST_ROT : ST_RD_WAIT;
      ST_ROT:     nxt = I_DCTL_ROT_DONE ? ST_WR_REQ : ST_ROT;
      ST_WR_REQ:  nxt = I_DCTL_DMA_READY ? ST_WR_WAIT : ST_WR_REQ;
      ST_WR_WAIT: nxt = leave ? ST_NEXT : ST_WR_WAIT;
      ST_NEXT:    nxt = last ? ST_FIN : ST_RD_REQ;
      ST_FIN:     nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
    if (kill) nxt = ST_IDLE;
  end
  always_comb begin
    src_d = accept ? I_DCTL_SRC_BASE : advance ? src + step : src;
    dst_d = accept ? I_DCTL_DST_BASE : advance ? dst + step : dst;
    blk_d = accept ? '0 : (advance && !last) ? blk + 1'b1 : blk;
    beats_d = accept ? I_DCTL_BEATS : beats;
    req_d = nxt == ST_RD_REQ || nxt == ST_WR_REQ;
    addr_d = nxt == ST_RD_REQ ? src_d : nxt == ST_WR_REQ ? dst_d : O_DCTL_DMA_ADDR;
    count_d = req_d ? beats_d : O_DCTL_DMA_COUNT;
    write_d = req_d ? nxt == ST_WR_REQ : O_DCTL_DMA_WRITE;
    busy_d = nxt != ST_IDLE && nxt != ST_FIN;
    rot_d = nxt == ST_ROT && state != ST_ROT;
  end
  always_ff @(posedge I_DCTL_HCLK)
    if (!I_DCTL_HRESET_N) begin
      src <= '0;
      dst <= '0;
      nblk <= '0;
      beats <= '0;
      blk <= '0;
      O_DCTL_DMA_ADDR <= '0;
      O_DCTL_DMA_COUNT <= '0;
      O_DCTL_DMA_WRITE <= 1'b0;
      O_DCTL_DMA_START <= 1'b0;
      O_DCTL_DMA_STOP <= 1'b0;
      O_DCTL_DMA_RESET <= 1'b0;
      O_DCTL_ROT_START <= 1'b0;
      O_DCTL_BUSY <= 1'b0;
      O_DCTL_DONE <= 1'b0;
      O_DCTL_ERR <= 1'b0;
    end else begin
      src <= src_d;
      dst <= dst_d;
      blk <= blk_d;
      beats <= beats_d;
      if (accept) nblk <= I_DCTL_NUM_BLOCKS;
      O_DCTL_DMA_ADDR <= addr_d;
      O_DCTL_DMA_COUNT <= count_d;
      O_DCTL_DMA_WRITE <= write_d;
      O_DCTL_DMA_START <= req_d;
      O_DCTL_DMA_STOP <= kill;
      O_DCTL_DMA_RESET <= kill;
      O_DCTL_ROT_START <= rot_d;
      O_DCTL_BUSY <= busy_d;
      O_DCTL_DONE <= nxt == ST_FIN;
      O_DCTL_ERR <= state == ST_IDLE && I_DCTL_START && !accept;
    end
endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

Block sequencer for the rotate datapath's DMA. It takes a frame job (source base, destination base, block count, beats per block) and steps the DMA through a repeating sequence for each block: burst-read into the input buffer, run the rotate core, burst-write the output buffer. It then advances both addresses and repeats until the frame is done. It sits between the register/config block and the DMA, and drives the DMA's request-side inputs.

## Interface
- `ADDR_W`, 32, AHB address width.
- `BLK_W`, 16, width of the block counter.
- `I_DCTL_HCLK`  in  1  AHB clock; single clock domain.
- `I_DCTL_HRESET_N`  in  1  reset; synchronous, active-low.
- `I_DCTL_START`  in  1  job start pulse; sampled only in IDLE.
- `I_DCTL_ABORT`  in  1  abort request; level-sampled.
- `I_DCTL_SRC_BASE`  in  ADDR_W  source frame base; word-aligned.
- `I_DCTL_DST_BASE`  in  ADDR_W  destination frame base; word-aligned.
- `I_DCTL_NUM_BLOCKS`  in  BLK_W  blocks per frame.
- `I_DCTL_BEATS`  in  5  words per burst, 1..16.
- `I_DCTL_DMA_READY`  in  1  DMA ready (first NSEQ of a burst).
- `I_DCTL_HTRANS`  in  2  monitored bus HTRANS.
- `I_DCTL_HREADY`  in  1  monitored bus HREADY.
- `I_DCTL_ROT_DONE`  in  1  rotate core finished the current block.
- `O_DCTL_DMA_ADDR`  out  ADDR_W  burst start address.
- `O_DCTL_DMA_COUNT`  out  5  burst beat count.
- `O_DCTL_DMA_SIZE`  out  3  transfer size; constant 3'b010 (word).
- `O_DCTL_DMA_WRITE`  out  1  0 = read into input buffer, 1 = write from output buffer.
- `O_DCTL_DMA_START`  out  1  burst request.
- `O_DCTL_DMA_STOP`  out  1  stop the current burst.
- `O_DCTL_DMA_RESET`  out  1  soft reset to the DMA.
- `O_DCTL_ROT_START`  out  1  one-cycle pulse that starts the rotate core.
- `O_DCTL_BUSY`  out  1  job in progress.
- `O_DCTL_DONE`  out  1  one-cycle pulse at frame completion.
- `O_DCTL_ERR`  out  1  one-cycle pulse when a start is rejected.
- `O_DCTL_BLK_IDX`  out  BLK_W  index of the current block.

## Operation
- **States:** IDLE, RD_REQ, RD_WAIT, ROT, WR_REQ, WR_WAIT, NEXT, FIN.
- **IDLE:**
  - START with NUM_BLOCKS==0 or BEATS==0 → ERR pulse, stay in IDLE.
  - Otherwise latch the bases, block count and beats; set BLK_IDX=0; go to RD_REQ.
- **RD_REQ / WR_REQ:**
  - Drive DMA_START=1, ADDR = current src/dst address, COUNT = beats, WRITE = 0 / 1.
  - Hold these until DMA_READY=1, then go to RD_WAIT / WR_WAIT and deassert START.
- **RD_WAIT / WR_WAIT:**
  - Beat counter increments when HTRANS[1]==1 and HREADY==1.
  - Transfer starts counting from the READY cycle, which counts as the first address beat.
  - After beat count == BEATS, wait for one further HREADY=1 (last data phase), then leave.
  - RD_WAIT → ROT; WR_WAIT → NEXT.
- **ROT:** ROT_START pulses on the first cycle in the state; wait for ROT_DONE, then go to WR_REQ.
- **NEXT:**
  - src += BEATS·4 and dst += BEATS·4, modulo 2^ADDR_W (wrap-around permitted, not flagged).
  - If BLK_IDX == NUM_BLOCKS−1 → FIN; else BLK_IDX += 1 and go to RD_REQ.
- **FIN:** DONE=1 for one cycle, then IDLE.
- **ABORT** in any state other than IDLE:
  - DMA_STOP=1 and DMA_RESET=1 for one cycle.
  - Go to IDLE; no DONE; BLK_IDX holds its last value.
  - ABORT in IDLE is ignored.
  - ABORT takes priority over every other transition in the same cycle.
- Job inputs are ignored while BUSY; START while BUSY is ignored, with no ERR.

## Timing
- All outputs are registered.
- **Reset values:** SIZE = 3'b010; all other outputs 0; state IDLE.
- START at edge N → BUSY=1 and DMA_START=1 after edge N+1.
- DMA_READY at edge M → DMA_START=0 after edge M+1.
- ROT_START is high for exactly the first cycle of ROT.
- ROT_DONE arriving in the same cycle as ROT_START is honoured: minimum ROT dwell is 1 cycle.
- BUSY falls in the same cycle DONE rises.
- START sampled in FIN is ignored; a new job needs IDLE.
- Reset asserted mid-job returns everything to reset values at the next edge; no STOP is issued.

## Structure
- Shared package `dctl_pkg`:
  - State enum.
  - SIZE_WORD = 3'b010.
  - HTRANS encodings: IDLE / BUSY / NSEQ / SEQ.
  - MAX_BEATS = 16.
- One sub-module, `dctl_beat_cnt`: a 5-bit beat counter with clear, a HTRANS/HREADY qualifier and a done flag. It is used by both wait states.

## Test plan
- **Single block, read then write.**
  - Setup: NUM_BLOCKS=1, BEATS=4, SRC=0x1000, DST=0x2000; DMA model with zero wait states.
  - Required: read burst at 0x1000 (WRITE=0); ROT_START pulse; write burst at 0x2000 (WRITE=1); DONE pulse; BUSY low.
- **Address stepping.**
  - Setup: NUM_BLOCKS=3, BEATS=16.
  - Required: source addresses 0x1000, 0x1040, 0x1080; BLK_IDX 0..2; exactly one DONE.
- **HREADY wait states.**
  - Setup: HREADY low for 3 cycles mid-burst.
  - Required: beat count is not advanced during the stalls; ROT is entered only after the 4th data phase.
- **Rejected start.**
  - Setup: BEATS=0 or NUM_BLOCKS=0.
  - Required: ERR pulses; BUSY stays 0; no DMA_START.
- **Abort.**
  - Setup: ABORT during WR_WAIT of block 1.
  - Required: one-cycle STOP + RESET; IDLE next cycle; no DONE; BLK_IDX=1.
- **Address wrap and reset.**
  - Setup: SRC=0xFFFF_FFC0, BEATS=16, 2 blocks.
  - Required: second source address is 0x0000_0000.
  - Additionally, HRESET_N low mid-ROT → all outputs at reset values the next cycle.
